// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and helpers for the data-memory controller
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic misaligned(input mem_size_t size, input logic [1:0] a);
        case (size)
            HALF_WORD: misaligned = a[0];
            WORD:      misaligned = |a;
            default:   misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input mem_size_t size, input logic [1:0] a);
        case (size)
            BYTE:      byte_en = 4'b0001 << a;
            HALF_WORD: byte_en = a[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    endfunction

    // Store data is right-aligned; replicate it so any enabled lane sees the right bits.
    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] d);
        case (size)
            BYTE:      lane_data = {4{d[7:0]}};
            HALF_WORD: lane_data = {2{d[15:0]}};
            default:   lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus between a core and the data-memory controller
interface dmem_ctrl_if;
    import risc_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the load lane from a RAM word and extends it
module dmem_load_align
    import risc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[8*addr +: 8];
        h = addr[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:      result = {{24{b[7]  & ~is_unsigned}}, b};
            HALF_WORD: result = {{16{h[15] & ~is_unsigned}}, h};
            default:   result = word;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-outstanding data-memory controller with fixed wait states
module dmem_ctrl
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus
);
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    dmem_state_t           state, state_nxt;
    logic [CW-1:0]         cnt;
    logic                  we_q;
    mem_size_t             size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  uns_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  leave_wait;
    logic                  fault;
    logic [31:0]           ram_word;
    logic [31:0]           load_data;
    logic [3:0]            be;
    logic [31:0]           wd;

    logic [31:0]           mem [WORDS];

    assign fault = misaligned(bus.req_size, bus.req_addr[1:0]) | (|bus.req_addr[31:ADDR_WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        accept        = 1'b0;
        leave_wait    = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = fault ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    leave_wait = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            size_q  <= BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
            wdata_q <= bus.req_wdata;
            uns_q   <= bus.req_unsigned;
            err_q   <= fault;
            rdata_q <= '0;
            cnt     <= CW'(WAIT_STATES);
        end else if (leave_wait) begin
            rdata_q <= we_q ? 32'd0 : load_data;
        end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
        end
    end

    // RAM is deliberately not reset; a reset mid-WAIT returns the FSM to IDLE so the commit never fires.
    assign be = byte_en(size_q, addr_q[1:0]);
    assign wd = lane_data(size_q, wdata_q);

    always_ff @(posedge clk) begin
        if (leave_wait && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign ram_word = mem[addr_q[ADDR_WIDTH-1:2]];

    dmem_load_align u_align (
        .word        (ram_word),
        .addr        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_data)
    );

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
    assign bus.rsp_err   = (state == RESP) ? err_q   : 1'b0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
    import risc_pkg::*;

    localparam int WS = 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] rd;
    logic        er;
    int          lt;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.ADDR_WIDTH(16), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request; lat counts clock edges after the accept edge until rsp_valid is seen.
    task automatic do_req(input logic we, input mem_size_t sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic uns, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        check("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_unsigned = uns;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = ~we;
        bus.req_addr     = 32'hFFFF_FFFF;
        bus.req_wdata    = 32'h5A5A_5A5A;
        bus.req_unsigned = ~uns;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_rsp_rdata", bus.rsp_rdata, rdata);
            check("stall_rsp_err",   {31'd0, bus.rsp_err}, {31'd0, err});
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = WORD;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_unsigned = 1'b0;
        bus.rsp_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b1, WORD, 32'h100, 32'hDEAD_BEEF, 1'b0, 0, rd, er, lt);
        check("sw100_err",   {31'd0, er}, 32'd0);
        check("sw100_rdata", rd, 32'd0);
        check("sw100_lat",   lt, WS + 1);
        do_req(1'b0, WORD, 32'h100, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw100_rdata", rd, 32'hDEAD_BEEF);
        check("lw100_err",   {31'd0, er}, 32'd0);
        check("lw100_lat",   lt, WS + 1);

        do_req(1'b1, WORD, 32'h200, 32'h0000_0000, 1'b0, 0, rd, er, lt);
        do_req(1'b1, BYTE, 32'h203, 32'h1234_5680, 1'b0, 0, rd, er, lt);
        check("sb203_err", {31'd0, er}, 32'd0);
        do_req(1'b0, BYTE, 32'h203, 32'd0, 1'b0, 0, rd, er, lt);
        check("lb203",  rd, 32'hFFFF_FF80);
        do_req(1'b0, BYTE, 32'h203, 32'd0, 1'b1, 0, rd, er, lt);
        check("lbu203", rd, 32'h0000_0080);
        do_req(1'b0, WORD, 32'h200, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw200",  rd, 32'h8000_0000);
        do_req(1'b0, HALF_WORD, 32'h202, 32'd0, 1'b0, 0, rd, er, lt);
        check("lh202",  rd, 32'hFFFF_8000);
        do_req(1'b0, HALF_WORD, 32'h202, 32'd0, 1'b1, 0, rd, er, lt);
        check("lhu202", rd, 32'h0000_8000);
        do_req(1'b0, BYTE, 32'h200, 32'd0, 1'b0, 0, rd, er, lt);
        check("lb200",  rd, 32'h0000_0000);

        do_req(1'b0, HALF_WORD, 32'h101, 32'd0, 1'b0, 0, rd, er, lt);
        check("lh101_err",   {31'd0, er}, 32'd1);
        check("lh101_rdata", rd, 32'd0);
        check("lh101_lat",   lt, 0);
        do_req(1'b1, WORD, 32'h102, 32'h0BAD_0BAD, 1'b0, 0, rd, er, lt);
        check("sw102_err", {31'd0, er}, 32'd1);
        check("sw102_lat", lt, 0);
        do_req(1'b0, WORD, 32'h100, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw100_after_mis", rd, 32'hDEAD_BEEF);

        do_req(1'b0, WORD, 32'h0001_0000, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw10000_err",   {31'd0, er}, 32'd1);
        check("lw10000_rdata", rd, 32'd0);
        check("lw10000_lat",   lt, 0);
        do_req(1'b1, WORD, 32'h0001_0100, 32'h1111_1111, 1'b0, 0, rd, er, lt);
        check("sw10100_err", {31'd0, er}, 32'd1);
        do_req(1'b0, WORD, 32'h100, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw100_after_oor", rd, 32'hDEAD_BEEF);

        do_req(1'b0, WORD, 32'h100, 32'd0, 1'b0, 5, rd, er, lt);
        check("stall_rdata",         rd, 32'hDEAD_BEEF);
        check("release_req_ready",   {31'd0, bus.req_ready}, 32'd1);
        check("release_rsp_valid",   {31'd0, bus.rsp_valid}, 32'd0);

        do_req(1'b1, WORD, 32'h300, 32'hCAFE_F00D, 1'b0, 0, rd, er, lt);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = WORD;
        bus.req_addr  = 32'h300;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("midrst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, WORD, 32'h300, 32'd0, 1'b0, 0, rd, er, lt);
        check("lw300_after_rst", rd, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, 16, byte-address width of the backing RAM (2**ADDR_WIDTH bytes).
REQ-002 SHALL provide parameter WAIT_STATES, 1, extra cycles between accept and response (0..15).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have req_valid  input  1  request present.
REQ-006 SHALL have req_ready  output  1  controller can accept a request.
REQ-007 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_size  input  mem_size_t  BYTE, HALF_WORD or WORD.
REQ-009 SHALL have req_addr  input  32  byte address.
REQ-010 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have rsp_valid  output  1  response present.
REQ-013 SHALL have rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have rsp_err  output  1  access faulted (misaligned or out of range).

Function
REQ-016 SHALL store data as 2**(ADDR_WIDTH-2) 32-bit words with per-byte write enables; RAM contents not reset.
REQ-017 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL accept when req_valid && req_ready, capturing we, size, addr, wdata, unsigned into registers.
REQ-019 SHALL flag misaligned: HALF_WORD with addr[0]=1, WORD with addr[1:0]!=0; BYTE never misaligned.
REQ-020 SHALL flag out-of-range when any req_addr[31:ADDR_WIDTH] bit is 1.
REQ-021 SHALL, on a faulted accept, go directly to RESP next cycle with rsp_err=1, rsp_rdata=0, and perform no RAM write.
REQ-022 SHALL, on a good accept, load a wait counter with WAIT_STATES and move to WAIT (WAIT_STATES=0: WAIT lasts one cycle).
REQ-023 SHALL decrement the counter each WAIT cycle and move to RESP when it reaches 0, so rsp_valid rises WAIT_STATES+1 cycles after accept.
REQ-024 SHALL commit a store's byte lanes (size and addr[1:0] select enables, wdata replicated to lanes) on the cycle leaving WAIT.
REQ-025 SHALL register load data on the cycle leaving WAIT: lane selected by addr[1:0], then zero- or sign-extended per req_unsigned; WORD unextended.
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE the next cycle.
REQ-027 SHALL not accept a new request in the RESP cycle (at most one outstanding access; no back-to-back in one cycle).
REQ-028 SHALL ignore req_* changes while not in IDLE.
REQ-029 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-030 SHALL on rst_n=0 immediately force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-031 SHALL discard an in-flight store if reset asserts before its commit cycle; RAM keeps prior contents.

Structure
REQ-032 SHALL use mem_size_t from risc_pkg; SHALL add dmem_state_t (IDLE, WAIT, RESP) to risc_pkg.
REQ-033 SHALL place lane-select/extension in sub-module dmem_load_align (combinational: word, addr[1:0], size, unsigned -> 32-bit result).
REQ-034 SHALL size the wait counter $clog2(WAIT_STATES+1), minimum 1 bit.

Verification
REQ-035 SW 0xDEADBEEF to 0x100, LW 0x100 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly WAIT_STATES+1 cycles after accept.
REQ-036 SB 0x80 to 0x203 over word 0 -> LB 0x203 = 0xFFFFFF80, LBU 0x203 = 0x00000080, LW 0x200 = 0x80000000.
REQ-037 LH 0x101 and SW 0x102 -> rsp_err=1, rsp_rdata=0, next-cycle response, LW 0x100 unchanged.
REQ-038 LW 0x00010000 with ADDR_WIDTH=16 -> rsp_err=1; no RAM modification.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0; release -> IDLE next cycle.
REQ-040 Assert rst_n=0 during WAIT of SW 0x12345678 to 0x300 -> outputs reset at once; LW 0x300 returns prior value.
